// File: rtl/carry_seq_pkg.sv
// Shared definitions for the nibble-serial carry-chain sequencer:
// FSM encoding, slice width and index-width helper.
package carry_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam int SLICE_W = 4;

    // A single-nibble build still needs a 1-bit index register.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_carry_slice.sv
// Purely combinational 4-bit adder slice; the carry pins are tagged so the
// packer maps them onto the dedicated carry chain.
module nibble_carry_slice (
    (* delay = "30e-12" *)              input  logic [3:0] I_A,
    (* delay = "30e-12" *)              input  logic [3:0] I_B,
    (* carry = "C", delay = "30e-12" *) input  logic       CIN,
                                        output logic [3:0] S,
    (* carry = "C" *)                   output logic       COUT
);

    logic [4:0] total;

    assign total = {1'b0, I_A} + {1'b0, I_B} + {4'b0000, CIN};
    assign S     = total[3:0];
    assign COUT  = total[4];

endmodule

// File: rtl/carry_chain_sequencer.sv
// WIDTH-bit adder that reuses one 4-bit carry slice, one nibble per cycle,
// LSB first, with the carry registered between passes.
module carry_chain_sequencer
    import carry_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             BUSY
);

    localparam int NIBBLES = WIDTH / SLICE_W;
    localparam int IDX_W   = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_bad_width
        $error("carry_chain_sequencer: WIDTH must be a multiple of 4 and at least 4");
    end

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;

    logic [SLICE_W-1:0] a_nib [NIBBLES];
    logic [SLICE_W-1:0] b_nib [NIBBLES];
    logic [SLICE_W-1:0] slice_s;
    logic               slice_c;

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign a_nib[gi] = a_q[gi*SLICE_W +: SLICE_W];
        assign b_nib[gi] = b_q[gi*SLICE_W +: SLICE_W];
    end

    nibble_carry_slice u_slice (
        .I_A  (a_nib[idx_q]),
        .I_B  (b_nib[idx_q]),
        .CIN  (carry_q),
        .S    (slice_s),
        .COUT (slice_c)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = CIN;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IDX_W'(n)) begin
                        sum_d[n*SLICE_W +: SLICE_W] = slice_s;
                    end
                end
                carry_d = slice_c;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d      = slice_c;
                    out_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // No accept on the handshake edge: IDLE must be visited first.
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign BUSY      = (state_q != IDLE);
    assign OUT_VALID = out_valid_q;
    assign SUM       = sum_q;
    assign COUT      = cout_q;

endmodule

// File: tb/tb_carry_chain_sequencer.sv
// Directed self-checking bench for carry_chain_sequencer (WIDTH=16 and WIDTH=4).
module tb_carry_chain_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [15:0] a, b, sum;

    logic        w4_in_valid, w4_in_ready, w4_cin, w4_out_valid, w4_out_ready, w4_cout, w4_busy;
    logic [3:0]  w4_a, w4_b, w4_sum;

    int n_cmp = 0;
    int n_mis = 0;

    carry_chain_sequencer #(.WIDTH(16)) dut (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .B(b), .CIN(cin), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .SUM(sum), .COUT(cout), .BUSY(busy)
    );

    carry_chain_sequencer #(.WIDTH(4)) dut4 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(w4_in_valid), .IN_READY(w4_in_ready),
        .A(w4_a), .B(w4_b), .CIN(w4_cin), .OUT_VALID(w4_out_valid), .OUT_READY(w4_out_ready),
        .SUM(w4_sum), .COUT(w4_cout), .BUSY(w4_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand set, wait (bounded) for the result, check it, hand it off.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                          input logic [15:0] es, input logic ec, input string tag);
        int n;
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, n, 32'd4);
        chk({tag, " sum"}, {16'd0, sum}, {16'd0, es});
        chk({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
        $display("op %s: 0x%04h + 0x%04h + %0d -> sum=0x%04h cout=%0d", tag, ta, tb, tc, sum, cout);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int acc1, acc2, results;
        logic pre_ready, got2;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        w4_in_valid = 1'b0; w4_out_ready = 1'b0; w4_a = '0; w4_b = '0; w4_cin = 1'b0;

        #3;
        chk("reset sum", {16'd0, sum}, 32'd0);
        chk("reset cout", {31'd0, cout}, 32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        #9 rst_n = 1'b1;
        #1;
        chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);

        // Basic op with cycle-by-cycle timing check.
        tick();
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1 busy after accept", {31'd0, busy}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("t1 out_valid early", {31'd0, out_valid}, 32'd0);
            chk("t1 in_ready low", {31'd0, in_ready}, 32'd0);
        end
        tick();
        chk("t1 out_valid", {31'd0, out_valid}, 32'd1);
        chk("t1 sum", {16'd0, sum}, 32'h5555);
        chk("t1 cout", {31'd0, cout}, 32'd0);
        chk("t1 in_ready in DONE", {31'd0, in_ready}, 32'd0);
        $display("op t1: 0x1234 + 0x4321 + 0 -> sum=0x%04h cout=%0d", sum, cout);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1 idle out_valid", {31'd0, out_valid}, 32'd0);
        chk("t1 idle in_ready", {31'd0, in_ready}, 32'd1);

        run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "ripple");
        run_op(16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, "intercarry");

        // Backpressure with new operands pending.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("bp out_valid", {31'd0, out_valid}, 32'd1);
        a = 16'h0101; b = 16'h0202; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp hold sum", {16'd0, sum}, 32'h3333);
            chk("bp hold cout", {31'd0, cout}, 32'd0);
            chk("bp hold out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp no accept", {31'd0, in_ready}, 32'd0);
        end
        $display("op bp1: 0x1111 + 0x2222 + 0 -> sum=0x%04h cout=%0d", sum, cout);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp release out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp pending accepted", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("bp2 out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp2 sum", {16'd0, sum}, 32'h0304);
        chk("bp2 cout", {31'd0, cout}, 32'd0);
        $display("op bp2: 0x0101 + 0x0202 + 1 -> sum=0x%04h cout=%0d", sum, cout);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset in the middle of RUN.
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset sum", {16'd0, sum}, 32'd0);
        chk("midreset cout", {31'd0, cout}, 32'd0);
        chk("midreset out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        #2 rst_n = 1'b1;
        #1;
        chk("midreset in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "after-reset");

        // Back-to-back with OUT_READY tied high.
        a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        acc1 = 0;
        acc2 = -1;
        got2 = 1'b0;
        results = 0;
        a = 16'h7FFF; b = 16'h0001;
        for (int i = 1; i <= 20; i++) begin
            pre_ready = in_ready;
            tick();
            if (pre_ready && !got2) begin
                acc2 = i;
                got2 = 1'b1;
                in_valid = 1'b0;
            end
            if (out_valid) begin
                results++;
                if (results == 1) begin
                    chk("b2b r1 sum", {16'd0, sum}, 32'h0000);
                    chk("b2b r1 cout", {31'd0, cout}, 32'd1);
                end else begin
                    chk("b2b r2 sum", {16'd0, sum}, 32'h8000);
                    chk("b2b r2 cout", {31'd0, cout}, 32'd0);
                end
                $display("op b2b%0d: sum=0x%04h cout=%0d", results, sum, cout);
            end
        end
        out_ready = 1'b0;
        chk("b2b spacing", acc2 - acc1, 32'd6);
        chk("b2b result count", results, 32'd2);

        // WIDTH=4 build: RUN lasts one cycle.
        w4_a = 4'hF; w4_b = 4'h1; w4_cin = 1'b1; w4_in_valid = 1'b1;
        chk("w4 in_ready", {31'd0, w4_in_ready}, 32'd1);
        tick();
        w4_in_valid = 1'b0;
        chk("w4 not yet valid", {31'd0, w4_out_valid}, 32'd0);
        tick();
        chk("w4 out_valid", {31'd0, w4_out_valid}, 32'd1);
        chk("w4 sum", {28'd0, w4_sum}, 32'h1);
        chk("w4 cout", {31'd0, w4_cout}, 32'd1);
        $display("op w4: 0xF + 0x1 + 1 -> sum=0x%0h cout=%0d", w4_sum, w4_cout);
        w4_out_ready = 1'b1;
        tick();
        w4_out_ready = 1'b0;
        chk("w4 idle", {31'd0, w4_busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
